// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad one column at a time, debounces
// presses and releases, and reports each accepted press as a single-cycle
// keystrobe with a 4-bit keycode (digits 0-9 map to their own value,
// A..D = 10..13, * = 14, # = 15).
//
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat. While a
// key stays held, keystrobe pulses again every REPEAT_CYCLES cycles. Without
// the macro the repeat counter is not built and each press gives one strobe.
module keypad_scanner #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_CYCLES   = 50000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       keystrobe,
  output logic [3:0] keycode,
  output logic       keyheld
);

  // Reject parameter values that would break the scan/debounce timing.
  if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("keypad_scanner: SCAN_DIV >= 4, DEBOUNCE_CYCLES >= 2, REPEAT_CYCLES >= 1 required");
  end

  // The shared counter must reach the largest terminal count in use.
  localparam int BASE_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
`ifdef KEYPAD_REPEAT_EN
  localparam int MAX_P    = (REPEAT_CYCLES > BASE_MAX) ? REPEAT_CYCLES : BASE_MAX;
`else
  localparam int MAX_P    = BASE_MAX;
`endif
  localparam int CNT_W    = (MAX_P > 2) ? $clog2(MAX_P) : 1;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  // The HELD cycle that first saw all rows low is the first cycle of the
  // release window, so RELEASE itself only needs DEBOUNCE_CYCLES-1 more.
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(DEBOUNCE_CYCLES - 2);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_e;

  state_e           state_q;
  logic [3:0]       sync1_q;
  logic [3:0]       srow_q;
  logic [3:0]       cols_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       row_q;
  logic             strobe_q;
  logic [3:0]       code_q;
  logic             held_q;
`ifdef KEYPAD_REPEAT_EN
  logic [CNT_W-1:0] rep_q;
`endif

  logic [1:0]       first_row;
  logic [1:0]       col_idx;
  logic [3:0]       cols_next;

  // Saturating increment: counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Key map lookup by {row, column}.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'd10;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = 4'd11;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = 4'd12;
      4'd12:   code = 4'd14;
      4'd13:   code = 4'd0;
      4'd14:   code = 4'd15;
      default: code = 4'd13;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous row lines.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its source, as real registers do.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= '0;
      srow_q  <= '0;
    end else begin
      sync1_q <= rows;
      srow_q  <= sync1_q;
    end
  end

  // Lowest active row index and one-hot column decode.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    first_row = 2'd0;
    col_idx   = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (srow_q[r]) first_row = 2'(r);
    end
    for (int c = 0; c < 4; c++) begin
      if (cols_q[c]) col_idx = 2'(c);
    end
  end

  assign cols_next = {cols_q[2:0], cols_q[3]};

  // Scan / debounce / hold / release controller with registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_SCAN;
      cols_q   <= 4'b0001;
      cnt_q    <= '0;
      row_q    <= 2'd0;
      strobe_q <= 1'b0;
      code_q   <= 4'd0;
      held_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q    <= '0;
`endif
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        ST_SCAN: begin
          // SCAN_DIV >= 4 lets the synchronizer settle on the new column
          // before the last dwell cycle samples it.
          if (cnt_q == SCAN_LAST) begin
            cnt_q <= '0;
            if (srow_q != 4'd0) begin
              row_q   <= first_row;
              state_q <= ST_DEBOUNCE;
            end else begin
              cols_q  <= cols_next;
            end
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        ST_DEBOUNCE: begin
          if (!srow_q[row_q]) begin
            // Bounce: resume scanning from the column that was frozen.
            cnt_q   <= '0;
            state_q <= ST_SCAN;
          end else if (cnt_q == DEB_LAST) begin
            code_q   <= key_code(row_q, col_idx);
            strobe_q <= 1'b1;
            held_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ST_HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_q    <= '0;
`endif
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        ST_HELD: begin
          if (srow_q == 4'd0) begin
            cnt_q   <= '0;
            state_q <= ST_RELEASE;
`ifdef KEYPAD_REPEAT_EN
            rep_q   <= '0;
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_q == REP_LAST) begin
              strobe_q <= 1'b1;
              rep_q    <= '0;
            end else begin
              rep_q <= sat_inc(rep_q);
            end
`endif
          end
        end

        ST_RELEASE: begin
          if (srow_q != 4'd0) begin
            // Release bounce: key is still down, no new strobe.
            state_q <= ST_HELD;
          end else if (cnt_q == REL_LAST) begin
            held_q  <= 1'b0;
            cnt_q   <= '0;
            cols_q  <= cols_next;
            state_q <= ST_SCAN;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        default: begin
          state_q <= ST_SCAN;
        end
      endcase
    end
  end

  assign cols      = cols_q;
  assign keystrobe = strobe_q;
  assign keycode   = code_q;
  assign keyheld   = held_q;

endmodule
